// File: rtl/product_assemble_pkg.sv
// Shared vALU definitions for the multiply back end: sew codes, widths,
// FSM states and the SEW64 partial-product shift tables.
package product_assemble_pkg;

    localparam int PROD_WIDTH   = 36;
    localparam int OUTPUT_WIDTH = 64;
    localparam int SEW_WIDTH    = 2;
    localparam int CHUNK        = 16;
    localparam int NUM_PROD     = 8;
    localparam int ACC_WIDTH    = 2 * OUTPUT_WIDTH;
    localparam int STAGES       = 2;

    typedef enum logic [SEW_WIDTH-1:0] {
        SEW_B = 2'b00,
        SEW_H = 2'b01,
        SEW_W = 2'b10,
        SEW_D = 2'b11
    } sew_e;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_HI = 1'b1
    } state_e;

    typedef logic [NUM_PROD-1:0][PROD_WIDTH-1:0] prod_vec_t;

    // Shift weights in CHUNK units, index 0 = m0_p0 ... index 7 = m3_p1
    localparam logic [NUM_PROD-1:0][2:0] W_BEAT0_CH =
        {3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    localparam logic [NUM_PROD-1:0][2:0] W_BEAT1_CH =
        {3'd6, 3'd5, 3'd5, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3};

    function automatic logic [ACC_WIDTH-1:0] sext_acc(input logic [PROD_WIDTH-1:0] p);
        return {{(ACC_WIDTH-PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
    endfunction

    function automatic logic [OUTPUT_WIDTH-1:0] sext_out(input logic [PROD_WIDTH-1:0] p);
        return {{(OUTPUT_WIDTH-PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
    endfunction

endpackage

// File: rtl/product_assemble_if.sv
// Product-beat / result bus between the multiplier array and the assembler.
interface product_assemble_if;
    import product_assemble_pkg::*;

    logic                    in_valid;
    logic [SEW_WIDTH-1:0]    sew;
    logic                    res_sel;
    logic [PROD_WIDTH-1:0]   m0_p0, m0_p1, m1_p0, m1_p1;
    logic [PROD_WIDTH-1:0]   m2_p0, m2_p1, m3_p0, m3_p1;
    logic                    out_valid;
    logic [OUTPUT_WIDTH-1:0] out_data;
    logic                    busy;

    modport master (
        output in_valid, sew, res_sel,
        output m0_p0, m0_p1, m1_p0, m1_p1, m2_p0, m2_p1, m3_p0, m3_p1,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, sew, res_sel,
        input  m0_p0, m0_p1, m1_p0, m1_p1, m2_p0, m2_p1, m3_p0, m3_p1,
        output out_valid, out_data, busy
    );

endinterface

// File: rtl/product_assemble_shift_sum.sv
// Combinational weighted adder: packs the eight partial products into a
// 128-bit full-product vector, element k at bits [2*SEW*k +: 2*SEW].
module product_shift_sum
    import product_assemble_pkg::*;
(
    input  logic [SEW_WIDTH-1:0] sew,
    input  logic                 beat1,
    input  prod_vec_t            prod,
    output logic [ACC_WIDTH-1:0] sum
);

    logic [OUTPUT_WIDTH-1:0] e_lo, e_hi;

    always_comb begin
        sum  = '0;
        e_lo = '0;
        e_hi = '0;
        if (beat1 || sew == SEW_D) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                sum = sum + (sext_acc(prod[i]) <<
                      (CHUNK * int'(beat1 ? W_BEAT1_CH[i] : W_BEAT0_CH[i])));
            end
        end else begin
            case (sew)
                SEW_B: begin
                    for (int k = 0; k < 8; k++) sum[16*k +: 16] = prod[7-k][15:0];
                end
                SEW_H: begin
                    sum[31:0]   = prod[7][31:0];
                    sum[63:32]  = prod[6][31:0];
                    sum[95:64]  = prod[1][31:0];
                    sum[127:96] = prod[0][31:0];
                end
                default: begin
                    e_lo = (sext_out(prod[4]) << 32)
                         + ((sext_out(prod[6]) + sext_out(prod[7])) << CHUNK)
                         + sext_out(prod[5]);
                    e_hi = (sext_out(prod[0]) << 32)
                         + ((sext_out(prod[2]) + sext_out(prod[3])) << CHUNK)
                         + sext_out(prod[1]);
                    sum  = {e_hi, e_lo};
                end
            endcase
        end
    end

endmodule

// File: rtl/product_assemble.sv
// Reassembles signed partial products into SEW element products; two-stage
// pipeline, SEW64 takes two beats joined through a 128-bit accumulator.
module product_assemble
    import product_assemble_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    product_assemble_if.slave bus
);

    state_e                  state_q, state_d;
    logic                    accept_single, accept_b0, accept_b1, issue;
    prod_vec_t               prod;
    logic [ACC_WIDTH-1:0]    beat_sum, full_sum;

    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    rs_lat_q, rs_lat_d;
    logic [ACC_WIDTH-1:0]    s1_sum_q, s1_sum_d;
    logic [SEW_WIDTH-1:0]    s1_sew_q, s1_sew_d;
    logic                    s1_rs_q, s1_rs_d;
    logic                    s1_wide_q, s1_wide_d;
    logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;

    assign prod = {bus.m3_p1, bus.m3_p0, bus.m2_p1, bus.m2_p0,
                   bus.m1_p1, bus.m1_p0, bus.m0_p1, bus.m0_p0};

    product_shift_sum u_shift_sum (
        .sew   (bus.sew),
        .beat1 (state_q == WAIT_HI),
        .prod  (prod),
        .sum   (beat_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid && bus.sew == SEW_D) state_d = WAIT_HI;
            WAIT_HI: if (bus.in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept_single = 1'b0;
        accept_b0     = 1'b0;
        accept_b1     = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                accept_single = bus.in_valid && bus.sew != SEW_D;
                accept_b0     = bus.in_valid && bus.sew == SEW_D;
            end
            WAIT_HI: begin
                accept_b1 = bus.in_valid;
                bus.busy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign issue = accept_single || accept_b1;

    // Pick the low or high SEW half of each 2*SEW element product
    function automatic logic [OUTPUT_WIDTH-1:0] pick_half(
        input logic [ACC_WIDTH-1:0] full, input logic [SEW_WIDTH-1:0] sew, input logic hi);
        logic [OUTPUT_WIDTH-1:0] r;
        r = '0;
        case (sew)
            SEW_B: for (int k = 0; k < 8; k++) r[8*k +: 8]   = full[16*k + (hi ? 8 : 0)  +: 8];
            SEW_H: for (int k = 0; k < 4; k++) r[16*k +: 16] = full[32*k + (hi ? 16 : 0) +: 16];
            SEW_W: for (int k = 0; k < 2; k++) r[32*k +: 32] = full[64*k + (hi ? 32 : 0) +: 32];
            default: r = hi ? full[127:64] : full[63:0];
        endcase
        return r;
    endfunction

    // Beat 1 of SEW64 lands in stage 1 alone; the accumulator joins it in stage 2
    assign full_sum = s1_sum_q + (s1_wide_q ? acc_q : '0);

    always_comb begin
        acc_d      = acc_q;
        rs_lat_d   = rs_lat_q;
        s1_sum_d   = s1_sum_q;
        s1_sew_d   = s1_sew_q;
        s1_rs_d    = s1_rs_q;
        s1_wide_d  = s1_wide_q;
        out_data_d = out_data_q;
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], issue};
        if (accept_b0) begin
            acc_d    = beat_sum;
            rs_lat_d = bus.res_sel;
        end
        if (issue) begin
            s1_sum_d  = beat_sum;
            s1_sew_d  = accept_b1 ? SEW_D : bus.sew;
            s1_rs_d   = accept_b1 ? rs_lat_q : bus.res_sel;
            s1_wide_d = accept_b1;
        end
        if (vld_pipe_q[1]) out_data_d = pick_half(full_sum, s1_sew_q, s1_rs_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            rs_lat_q   <= 1'b0;
            s1_sum_q   <= '0;
            s1_sew_q   <= '0;
            s1_rs_q    <= 1'b0;
            s1_wide_q  <= 1'b0;
            vld_pipe_q <= '0;
            out_data_q <= '0;
        end else begin
            acc_q      <= acc_d;
            rs_lat_q   <= rs_lat_d;
            s1_sum_q   <= s1_sum_d;
            s1_sew_q   <= s1_sew_d;
            s1_rs_q    <= s1_rs_d;
            s1_wide_q  <= s1_wide_d;
            vld_pipe_q <= vld_pipe_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_product_assemble.sv
// Directed + random bench for product_assemble with a cycle-level result model.
module tb_product_assemble;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    product_assemble_if bus();

    product_assemble dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [127:0] sx(input logic [35:0] v);
        return {{92{v[35]}}, v};
    endfunction

    function automatic logic [63:0] model_single(input logic [1:0] sew, input logic hi,
                                                 input logic [7:0][35:0] p);
        logic [63:0] r;
        logic [63:0] e0, e1;
        r = '0;
        case (sew)
            2'd0: for (int k = 0; k < 8; k++) r[8*k +: 8] = hi ? p[7-k][15:8] : p[7-k][7:0];
            2'd1: begin
                r[15:0]  = hi ? p[7][31:16] : p[7][15:0];
                r[31:16] = hi ? p[6][31:16] : p[6][15:0];
                r[47:32] = hi ? p[1][31:16] : p[1][15:0];
                r[63:48] = hi ? p[0][31:16] : p[0][15:0];
            end
            default: begin
                e0 = 64'(sx(p[4]) * 128'h1_0000_0000 + (sx(p[6]) + sx(p[7])) * 128'h1_0000 + sx(p[5]));
                e1 = 64'(sx(p[0]) * 128'h1_0000_0000 + (sx(p[2]) + sx(p[3])) * 128'h1_0000 + sx(p[1]));
                r  = hi ? {e1[63:32], e0[63:32]} : {e1[31:0], e0[31:0]};
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] model_wide(input logic [7:0][35:0] b0,
                                               input logic [7:0][35:0] b1, input logic hi);
        int w0[8] = '{0, 16, 16, 32, 32, 32, 48, 48};
        int w1[8] = '{48, 48, 64, 64, 64, 80, 80, 96};
        logic [127:0] tot;
        tot = '0;
        for (int i = 0; i < 8; i++) begin
            tot = tot + sx(b0[i]) * (128'd1 << w0[i]);
            tot = tot + sx(b1[i]) * (128'd1 << w1[i]);
        end
        return hi ? tot[127:64] : tot[63:0];
    endfunction

    logic [7:0][35:0] cur;
    assign cur = {bus.m3_p1, bus.m3_p0, bus.m2_p1, bus.m2_p0,
                  bus.m1_p1, bus.m1_p0, bus.m0_p1, bus.m0_p0};

    bit               m_busy, m_s1v, m_s2v, m_b0_rs;
    logic [63:0]      m_s1d, m_last;
    logic [7:0][35:0] m_b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_s1v = 1'b0; m_s2v = 1'b0; m_last = '0;
        end else begin
            m_s2v = m_s1v;
            if (m_s1v) m_last = m_s1d;
            m_s1v = 1'b0;
            if (bus.in_valid) begin
                if (m_busy) begin
                    m_s1v  = 1'b1;
                    m_s1d  = model_wide(m_b0, cur, m_b0_rs);
                    m_busy = 1'b0;
                end else if (bus.sew == 2'b11) begin
                    m_busy  = 1'b1;
                    m_b0    = cur;
                    m_b0_rs = bus.res_sel;
                end else begin
                    m_s1v = 1'b1;
                    m_s1d = model_single(bus.sew, bus.res_sel, cur);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(m_s2v));
            chk("out_data", bus.out_data, m_last);
            chk("busy", 64'(bus.busy), 64'(m_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic hi,
                         input logic [7:0][35:0] p);
        bus.in_valid = v; bus.sew = s; bus.res_sel = hi;
        bus.m0_p0 = p[0]; bus.m0_p1 = p[1]; bus.m1_p0 = p[2]; bus.m1_p1 = p[3];
        bus.m2_p0 = p[4]; bus.m2_p1 = p[5]; bus.m3_p0 = p[6]; bus.m3_p1 = p[7];
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, '0);
    endtask

    logic [7:0][35:0] p;

    initial begin
        idle();
        step(); step();
        chk_en = 1'b1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        // SEW8 low / high halves, latency 2
        for (int h = 0; h < 2; h++) begin
            p = '0; p[7] = 36'h0_0000_FE01;
            drive(1'b1, 2'd0, h[0], p);
            step(); idle();
            chk("sew8_lat1", 64'(bus.out_valid), 64'd0);
            step();
            chk("sew8_valid", 64'(bus.out_valid), 64'd1);
            chk("sew8_data", bus.out_data, h ? 64'hFE : 64'h01);
        end

        // SEW16 high halves
        p = '0; p[7] = 36'hF_FFFF_FFFF; p[0] = 36'h0_0001_0000;
        drive(1'b1, 2'd1, 1'b1, p);
        step(); idle(); step();
        chk("sew16_data", bus.out_data, 64'h0001_0000_0000_FFFF);

        // SEW32: A1B1 lands at bit 32 of e0
        for (int h = 0; h < 2; h++) begin
            p = '0; p[4] = 36'd1;
            drive(1'b1, 2'd2, h[0], p);
            step(); idle(); step();
            chk("sew32_data", bus.out_data, h ? 64'h1 : 64'h0);
        end

        // SEW64 with a gap; beat 1 carries other sew/res_sel that must be ignored
        drive(1'b1, 2'd3, 1'b1, '0);
        step(); idle();
        chk("sew64_b0_busy", 64'(bus.busy), 64'd1);
        for (int g = 0; g < 3; g++) begin
            step();
            chk("sew64_gap_busy", 64'(bus.busy), 64'd1);
            chk("sew64_gap_nov", 64'(bus.out_valid), 64'd0);
        end
        p = '0; p[7] = 36'd1;
        drive(1'b1, 2'd0, 1'b0, p);
        step(); idle();
        chk("sew64_b1_busy", 64'(bus.busy), 64'd0);
        chk("sew64_b1_nov", 64'(bus.out_valid), 64'd0);
        step();
        chk("sew64_valid", 64'(bus.out_valid), 64'd1);
        chk("sew64_data", bus.out_data, 64'h0000_0001_0000_0000);

        // Reset aborts a pending SEW64 and drops an in-flight single result
        p = '0; p[0] = 36'd5;
        drive(1'b1, 2'd3, 1'b0, p);
        step(); idle();
        rst = 1'b1; step(); rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        p = '0; p[7] = 36'd9;
        drive(1'b1, 2'd0, 1'b0, p);
        step(); idle();
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("drop_nov", 64'(bus.out_valid), 64'd0);
        p = '0; p[7] = 36'd5;
        drive(1'b1, 2'd0, 1'b0, p);
        step(); idle(); step();
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_data", bus.out_data, 64'h05);

        // Back-to-back SEW8 beats
        for (int k = 1; k <= 8; k++) begin
            p = '0; p[7] = 36'(k);
            drive(1'b1, 2'd0, 1'b0, p);
            step();
            if (k > 1) chk("b2b", {55'd0, bus.out_valid, bus.out_data[7:0]}, {55'd0, 1'b1, 8'(k-1)});
        end
        idle(); step();
        chk("b2b_last", {55'd0, bus.out_valid, bus.out_data[7:0]}, {55'd0, 1'b1, 8'd8});

        // Random traffic, checked by the model every cycle
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 8; i++) p[i] = {4'($urandom), 32'($urandom)};
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom), p);
            step();
        end
        idle();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
